// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, controller states and
// the bit positions of the {C,V,N,Z} flag vector.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_CMP = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic logic op_is_shift(input logic [3:0] op_i);
        return (op_i == OP_SHL) || (op_i == OP_SHR);
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Unsigned shift-add multiplier: one partial-product step per cycle for WIDTH
// cycles. o_done flags the final step, and o_lo/o_hi carry that step's result.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    // The multiplier occupies the low half and is consumed LSB-first as the product shifts in.
    always_comb begin
        if (r_lo[0]) begin
            w_sum = {1'b0, r_hi} + {1'b0, r_mcand};
        end else begin
            w_sum = {1'b0, r_hi};
        end
        w_hi_next = w_sum[WIDTH:1];
        w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end

    assign o_done = r_busy && (r_cnt == CW'(1));
    assign o_lo   = w_lo_next;
    assign o_hi   = w_hi_next;

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH);
            r_mcand <= i_a;
            r_hi    <= '0;
            r_lo    <= i_b;
        end else if (r_busy) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts and a
// shift-add multiplier behind a valid/ready request and result handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_hi,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_zhi;
    logic [3:0]       r_flags;
    logic             r_err;

    logic             w_accept;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_out;
    logic [3:0]       w_sh_flags;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_mul_hi;
    logic [3:0]       w_mul_flags;

    assign in_ready    = (r_state == ST_IDLE) && !rst;
    assign out_valid   = (r_state == ST_DONE);
    assign z           = r_z;
    assign z_hi        = r_zhi;
    assign flags       = r_flags;
    assign err         = r_err;
    assign w_accept    = in_valid && in_ready;
    assign w_shamt     = bus[SHW-1:0];
    assign w_sum       = {1'b0, acc} + {1'b0, bus};
    assign w_diff      = {1'b0, acc} - {1'b0, bus};
    assign w_mul_start = w_accept && (op == OP_MUL);

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_start),
        .i_a     (acc),
        .i_b     (bus),
        .o_done  (w_mul_done),
        .o_lo    (w_mul_lo),
        .o_hi    (w_mul_hi)
    );

    // Single-cycle result and flags, evaluated on the live request operands.
    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        w_flags = 4'b0000;
        case (op)
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (acc[MSB] == bus[MSB]) && (w_sum[MSB] != acc[MSB]);
            end
            OP_SUB, OP_CMP: begin
                w_res = (op == OP_CMP) ? '0 : w_diff[MSB:0];
                w_c   = w_diff[WIDTH];
                w_v   = (acc[MSB] != bus[MSB]) && (w_diff[MSB] != acc[MSB]);
            end
            OP_AND:         w_res = acc & bus;
            OP_OR:          w_res = acc | bus;
            OP_XOR:         w_res = acc ^ bus;
            OP_SHL, OP_SHR: w_res = acc;
            OP_MUL:         w_res = '0;
            default:        w_err = 1'b1;
        endcase
        if (w_err) begin
            w_flags = 4'b0000;
        end else if (op == OP_CMP) begin
            w_flags[FLAG_C] = w_c;
            w_flags[FLAG_V] = w_v;
            w_flags[FLAG_N] = w_diff[MSB];
            w_flags[FLAG_Z] = (acc == bus);
        end else begin
            w_flags[FLAG_C] = w_c;
            w_flags[FLAG_V] = w_v;
            w_flags[FLAG_N] = w_res[MSB];
            w_flags[FLAG_Z] = (w_res == '0);
        end
    end

    // Next shift step and the flags of the shift and multiply completions.
    always_comb begin
        if (r_op == OP_SHL) begin
            w_sh_next = {r_work[MSB-1:0], 1'b0};
            w_sh_out  = r_work[MSB];
        end else begin
            w_sh_next = {1'b0, r_work[MSB:1]};
            w_sh_out  = r_work[0];
        end
        w_sh_flags          = 4'b0000;
        w_sh_flags[FLAG_C]  = w_sh_out;
        w_sh_flags[FLAG_N]  = w_sh_next[MSB];
        w_sh_flags[FLAG_Z]  = (w_sh_next == '0);
        w_mul_flags         = 4'b0000;
        w_mul_flags[FLAG_C] = (w_mul_hi != '0);
        w_mul_flags[FLAG_V] = (w_mul_hi != '0);
        w_mul_flags[FLAG_N] = w_mul_lo[MSB];
        w_mul_flags[FLAG_Z] = (w_mul_lo == '0);
    end

    // Controller FSM with registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= 4'd0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_z     <= '0;
            r_zhi   <= '0;
            r_flags <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= op;
                        if (op == OP_MUL) begin
                            r_state <= ST_EXEC;
                            r_err   <= 1'b0;
                        end else if (op_is_shift(op) && (w_shamt != '0)) begin
                            r_state <= ST_EXEC;
                            r_work  <= acc;
                            r_cnt   <= w_shamt;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                            r_z     <= w_res;
                            r_zhi   <= '0;
                            r_flags <= w_flags;
                            r_err   <= w_err;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_MUL) begin
                        if (w_mul_done) begin
                            r_state <= ST_DONE;
                            r_z     <= w_mul_lo;
                            r_zhi   <= w_mul_hi;
                            r_flags <= w_mul_flags;
                        end
                    end else begin
                        r_work <= w_sh_next;
                        r_cnt  <= r_cnt - SHW'(1);
                        if (r_cnt == SHW'(1)) begin
                            r_state <= ST_DONE;
                            r_z     <= w_sh_next;
                            r_zhi   <= '0;
                            r_flags <= w_sh_flags;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed corner cases, handshake
// and reset scenarios, and randomized ops against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] acc;
    logic [W-1:0] bus;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic [W-1:0] z_hi;
    logic [3:0]   flags;
    logic         err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] zhi;
        logic [7:0] z;
        logic [3:0] flags;
        logic       err;
    } res_t;

    typedef struct packed {
        logic [3:0] o;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic [7:0] zhi;
        logic [3:0] f;
        logic       e;
        logic [3:0] lat;
    } vec_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc       (acc),
        .bus       (bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .z_hi      (z_hi),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the opcode's definition.
    function automatic res_t ref_model(input int o, input int a, input int b);
        res_t r;
        int s, sa, sb, sh, zi, hi;
        logic c, v;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        zi = 0;
        hi = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        case (o)
            0: begin s = a + b; zi = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            1, 2: begin s = a - b; zi = (s + 256) % 256; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
            3: zi = a & b;
            4: zi = a | b;
            5: zi = a ^ b;
            6: begin zi = (a << sh) % 256; c = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
            7: begin zi = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            8: begin s = a * b; zi = s % 256; hi = s / 256; c = (hi != 0); v = c; end
            default: begin r.err = 1'b1; return r; end
        endcase
        r.zhi = 8'(hi);
        if (o == 2) begin
            r.z     = 8'd0;
            r.flags = {c, v, (zi >= 128), (a == b)};
        end else begin
            r.z     = 8'(zi);
            r.flags = {c, v, (zi >= 128), (zi == 0)};
        end
        return r;
    endfunction

    function automatic int ref_lat(input int o, input int b);
        if (o == 8) return W + 1;
        if ((o == 6) || (o == 7)) return ((b % 8) == 0) ? 1 : (b % 8) + 1;
        return 1;
    endfunction

    // Drives one request from a post-edge point, releases the result, returns what was seen.
    task automatic apply(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         output res_t r, output int lat, output logic rdy);
        rdy      = in_ready;
        in_valid = 1'b1;
        op       = o;
        acc      = a;
        bus      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        acc      = 8'($urandom);
        bus      = 8'($urandom);
        lat      = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        r = {z_hi, z, flags, err};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready, out_valid, z, z_hi, flags, err} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b ov=%b z=%h zhi=%h f=%b err=%b, want all zero",
                     in_ready, out_valid, z, z_hi, flags, err);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t tbl [0:10];
        res_t r;
        int   lat;
        logic rdy;
        tbl = '{
            '{4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001, 1'b0, 4'd1},
            '{4'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100, 1'b0, 4'd1},
            '{4'd2, 8'h05, 8'h07, 8'h00, 8'h00, 4'b1010, 1'b0, 4'd1},
            '{4'd8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1100, 1'b0, 4'd9},
            '{4'd8, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0010, 1'b0, 4'd9},
            '{4'd7, 8'h81, 8'h01, 8'h40, 8'h00, 4'b1000, 1'b0, 4'd2},
            '{4'd6, 8'h81, 8'h03, 8'h08, 8'h00, 4'b0000, 1'b0, 4'd4},
            '{4'd6, 8'h5A, 8'h08, 8'h5A, 8'h00, 4'b0000, 1'b0, 4'd1},
            '{4'd7, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 4'd1},
            '{4'd12, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0000, 1'b1, 4'd1},
            '{4'd0, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1'b0, 4'd1}
        };
        for (int i = 0; i <= 10; i++) begin
            apply(tbl[i].o, tbl[i].a, tbl[i].b, r, lat, rdy);
            n_vec++;
            if ((r !== {tbl[i].zhi, tbl[i].z, tbl[i].f, tbl[i].e}) || (lat != int'(tbl[i].lat)) || (rdy !== 1'b1)) begin
                n_err++;
                $display("FAIL directed_%0d op=%0d: got zhi=%h z=%h f=%b err=%b lat=%0d rdy=%b, want zhi=%h z=%h f=%b err=%b lat=%0d rdy=1",
                         i, tbl[i].o, r.zhi, r.z, r.flags, r.err, lat, rdy,
                         tbl[i].zhi, tbl[i].z, tbl[i].f, tbl[i].e, tbl[i].lat);
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        op       = 4'd0;
        acc      = 8'h12;
        bus      = 8'h34;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            op  = 4'd1;
            acc = 8'($urandom);
            bus = 8'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if ({out_valid, in_ready, z, z_hi, flags, err} !== {1'b1, 1'b0, 8'h46, 8'h00, 4'b0000, 1'b0}) begin
                n_err++;
                $display("FAIL hold_%0d: got ov=%b rdy=%b z=%h zhi=%h f=%b err=%b, want ov=1 rdy=0 z=46 zhi=00 f=0000 err=0",
                         i, out_valid, in_ready, z, z_hi, flags, err);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL release: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL no_queued_request: got ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_mul_reset();
        res_t r;
        int   lat;
        logic rdy;
        int   seen;
        apply(4'd0, 8'h01, 8'h01, r, lat, rdy);
        in_valid = 1'b1;
        op       = 4'd8;
        acc      = 8'hFF;
        bus      = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({out_valid, in_ready, z, z_hi, flags, err} !== 22'd0) begin
            n_err++;
            $display("FAIL mul_reset_clear: got ov=%b rdy=%b z=%h zhi=%h f=%b err=%b, want all zero",
                     out_valid, in_ready, z, z_hi, flags, err);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mul_reset_ready: got in_ready=%b want 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL mul_discarded: got %0d out_valid cycles, want 0", seen);
        end
        apply(4'd8, 8'h03, 8'h05, r, lat, rdy);
        n_vec++;
        if ((r !== ref_model(8, 3, 5)) || (lat != W + 1)) begin
            n_err++;
            $display("FAIL mul_after_reset: got z=%h zhi=%h f=%b lat=%0d, want z=0f zhi=00 f=0000 lat=%0d",
                     r.z, r.zhi, r.flags, lat, W + 1);
        end
    endtask

    task automatic test_random();
        res_t r;
        res_t exp_r;
        int   lat;
        logic rdy;
        int   o, a, b;
        for (int i = 0; i < 60; i++) begin
            o = (i < 45) ? $urandom_range(0, 8) : $urandom_range(0, 15);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            exp_r = ref_model(o, a, b);
            apply(4'(o), 8'(a), 8'(b), r, lat, rdy);
            n_vec++;
            if ((r !== exp_r) || (lat != ref_lat(o, b)) || (rdy !== 1'b1)) begin
                n_err++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got zhi=%h z=%h f=%b err=%b lat=%0d rdy=%b, want zhi=%h z=%h f=%b err=%b lat=%0d rdy=1",
                         i, o, a, b, r.zhi, r.z, r.flags, r.err, lat, rdy,
                         exp_r.zhi, exp_r.z, exp_r.flags, exp_r.err, ref_lat(o, b));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        acc       = '0;
        bus       = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_mul_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 8, datapath width in bits (power of two, 4..64).
REQ-002 SHALL have derived constant SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port: in_valid  in  1  request present.
REQ-006 SHALL have port: in_ready  out  1  block can accept a request.
REQ-007 SHALL have port: op  in  4  opcode.
REQ-008 SHALL have port: acc  in  WIDTH  first operand.
REQ-009 SHALL have port: bus  in  WIDTH  second operand; the shift amount for shifts is bus[SHW-1:0].
REQ-010 SHALL have port: out_valid  out  1  result present.
REQ-011 SHALL have port: out_ready  in  1  consumer accepts the result.
REQ-012 SHALL have port: z  out  WIDTH  result, low half.
REQ-013 SHALL have port: z_hi  out  WIDTH  high half of the MUL product; 0 for all other ops.
REQ-014 SHALL have port: flags  out  4  {C,V,N,Z}.
REQ-015 SHALL have port: err  out  1  illegal opcode flag.

Function
REQ-016 SHALL decode op as: 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 MUL, 9-15 illegal.
REQ-017 SHALL use FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 SHALL accept a request on an edge where in_valid && in_ready, registering op, acc and bus; operand changes after acceptance are ignored.
REQ-019 SHALL treat ADD/SUB/CMP/logic/illegal ops as single-cycle: IDLE->DONE, with out_valid high on the cycle after acceptance.
REQ-020 SHALL, for ADD: z = acc+bus mod 2^WIDTH, C = carry out, V = signed overflow.
REQ-021 SHALL, for SUB: z = acc-bus mod 2^WIDTH, C = borrow (acc < bus unsigned), V = signed overflow.
REQ-022 SHALL, for CMP: compute flags as for SUB, with z = 0.
REQ-023 SHALL, for AND/OR/XOR: z = bitwise result, C = 0, V = 0.
REQ-024 SHALL, for all ops: N = z[WIDTH-1]; Z = (z == 0), except CMP, where Z = (acc == bus) and N = MSB of the difference.
REQ-025 SHALL execute SHL/SHR one bit per cycle in EXEC for shamt cycles, zero fill; C = last bit shifted out; V = 0.
REQ-026 SHALL, for a shift with shamt = 0: go IDLE->DONE, with z = acc and C = 0.
REQ-027 SHALL execute MUL as an unsigned shift-add over exactly WIDTH EXEC cycles; {z_hi,z} = acc*bus; C = V = (z_hi != 0); Z and N are evaluated on z.
REQ-028 SHALL, for an illegal opcode: z = 0, z_hi = 0, flags = 0, err = 1, single-cycle latency.
REQ-029 SHALL clear err on the next accepted legal op.
REQ-030 SHALL, in DONE, hold z, z_hi, flags and err stable until out_ready.
REQ-031 SHALL transition DONE->IDLE on out_ready; a new request is accepted no earlier than the following edge.
REQ-032 SHALL ignore in_valid while not in IDLE; no request is queued or lost-accepted.

Reset
REQ-033 SHALL, while rst = 1 at an edge, set state = IDLE and z = z_hi = flags = err = out_valid = 0, including mid-EXEC, where the in-flight op is discarded.
REQ-034 SHALL hold in_ready = 0 during cycles in which rst = 1, and drive in_ready = 1 from the first cycle after rst is released.

Structure
REQ-035 SHALL place the opcode enum, FSM state enum and flag bit-index constants in shared package alu_pkg.
REQ-036 SHALL implement the MUL datapath as sub-module seq_mul (start/done handshake, WIDTH parameter); shifts and single-cycle ops remain in seq_alu.

Verification (WIDTH=8)
REQ-037 SHALL cover: ADD 0xFF+0x01 -> z=0x00, C=1, Z=1, V=0, out_valid 1 cycle after accept.
REQ-038 SHALL cover: SUB 0x80-0x01 -> z=0x7F, V=1, C=0; CMP 0x05,0x07 -> z=0x00, C=1, N=1, Z=0.
REQ-039 SHALL cover: MUL 0xFF*0xFF -> z_hi=0xFE, z=0x01, C=1, out_valid 9 cycles after accept; MUL 0x0F*0x11 -> z=0xFF, z_hi=0x00, C=0.
REQ-040 SHALL cover: SHR 0x81 by 1 -> z=0x40, C=1; SHL 0x81 by 3 -> z=0x08, C=0; shamt 0 -> z=acc, latency 1.
REQ-041 SHALL cover: out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, a concurrent second request is not accepted; op 0xC -> err=1, z=0.
REQ-042 SHALL cover: rst asserted on the 4th cycle of a MUL -> next cycle out_valid=0, all outputs 0; in_ready=1 after release.
